bit_serial_adder_ctrl: RTL



---
 rtl/bit_serial_adder_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bit_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// bit_serial_adder_ctrl
//
// Purpose:
//   Computes a WIDTH-bit sum one bit per clock, LSB first, using a single
//   1-bit full adder. Operands live in right-shifting registers, the carry is
//   kept in a flip-flop between cycles, and a start/busy/done handshake
//   sequences the operation (IDLE -> RUN for WIDTH cycles -> DONE -> IDLE).
//
// Optional feature:
//   SERIAL_SUB_EN : when defined, adds input 'sub'. With sub=1 the block
//                   computes a - b (b inverted, carry forced to 1, cin ignored);
//                   cout=1 then means no borrow.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32), default 8.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request a new operation, sampled only in IDLE
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   sub    in   1      (SERIAL_SUB_EN only) subtract request
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse, sum/cout valid
//   sum    out  WIDTH  result register, held until the next DONE
//   cout   out  1      final carry-out register, held until the next DONE
// -----------------------------------------------------------------------------

// Purely combinational 1-bit full adder shared by the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module bit_serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic             fa_s_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] b_load_s;
    logic             carry_load_s;
    logic [WIDTH-1:0] sum_next_s;

    full_adder u_fa (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .s    (fa_s_s),
        .cout (fa_cout_s)
    );

    // Right-shift the new sum bit in at the MSB; after WIDTH shifts bit 0 lands at sum[0].
    assign sum_next_s = {fa_s_s, sum_sh_r[WIDTH-1:1]};

    // Operand B / initial carry selection at the accepting edge.
    always_comb begin
        b_load_s     = b;
        carry_load_s = cin;
`ifdef SERIAL_SUB_EN
        // Two's-complement subtraction: a + ~b + 1.
        if (sub) begin
            b_load_s     = ~b;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = b;
            carry_load_s = cin;
        end
`endif
    end

    // Sequencing FSM with shift datapath and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            sum_sh_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= {WIDTH{1'b0}};
            cout     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b_load_s;
                        carry_r  <= carry_load_s;
                        cnt_r    <= {CW{1'b0}};
                        sum_sh_r <= {WIDTH{1'b0}};
                        busy     <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy     <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    sum_sh_r <= sum_next_s;
                    carry_r  <= fa_cout_s;
                    cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_BIT) begin
                        // This edge processes the final bit: publish the result.
                        sum     <= sum_next_s;
                        cout    <= fa_cout_s;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
